// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline. It arbitrates
// memory stalls, taken branches, instruction fetch waits and load-use hazards,
// and drives the load enables and flush/bubble controls of every stage register.
//
// Ports
//   clk            sole clock, all state updates on the rising edge
//   reset          asynchronous active-high reset
//   id_sr1/id_sr2  source register numbers of the instruction in decode
//   id_uses_sr1/2  decode instruction actually reads that source
//   ex_dest        destination register of the instruction in ID/EX
//   ex_is_load     ID/EX instruction is a load
//   ex_valid       ID/EX holds a valid instruction
//   imem_resp      instruction fetch completes this cycle
//   dmem_req       MEM stage access pending
//   dmem_resp      MEM stage access completes this cycle
//   br_taken       MEM stage resolved a taken branch, JMP or TRAP
//   pc_load .. mem_wb_load          stage register load enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_flush                    stage loads a NOP/invalid entry instead
//   mem_wait       high while the controller sits in MEM_WAIT
//
// Optional feature (macro PIPE_CTRL_PERF_CNT_EN)
//   stall_cycles   saturating count of cycles with pc_load low
//   bubble_count   saturating count of cycles with id_ex_bubble high
// -----------------------------------------------------------------------------
module pipeline_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] id_sr1,
  input  logic [2:0] id_sr2,
  input  logic       id_uses_sr1,
  input  logic       id_uses_sr2,
  input  logic [2:0] ex_dest,
  input  logic       ex_is_load,
  input  logic       ex_valid,
  input  logic       imem_resp,
  input  logic       dmem_req,
  input  logic       dmem_resp,
  input  logic       br_taken,
  output logic       pc_load,
  output logic       if_id_load,
  output logic       id_ex_load,
  output logic       ex_mem_load,
  output logic       mem_wb_load,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_flush,
  output logic       mem_wait
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] bubble_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_t;

  // Control vector layout:
  // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_bubble, ex_mem_flush}
  localparam logic [7:0] CTRL_HOLD   = 8'b00000_000;
  localparam logic [7:0] CTRL_BRANCH = 8'b11111_111;
  localparam logic [7:0] CTRL_IFETCH = 8'b01111_100;
  localparam logic [7:0] CTRL_LDUSE  = 8'b00111_010;
  localparam logic [7:0] CTRL_NORMAL = 8'b11111_000;
  localparam logic [7:0] CTRL_FLUSH  = 8'b11111_100;
  localparam logic [7:0] CTRL_RESET  = 8'b00000_111;

  state_t     state, state_next;
  logic       flush_pend, flush_pend_next;
  logic       mem_stall, load_use;
  logic [7:0] run_ctrl, ctrl;

  assign mem_stall = dmem_req & ~dmem_resp;
  assign load_use  = ex_valid & ex_is_load &
                     ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                      (id_uses_sr2 & (id_sr2 == ex_dest)));

  // Controls for a cycle in which memory is not stalling; shared by RUN and
  // by the response cycle that ends a MEM_WAIT.
  always_comb begin
    if (br_taken)
      run_ctrl = CTRL_BRANCH;
    else if (!imem_resp)
      run_ctrl = CTRL_IFETCH;
    else if (load_use)
      run_ctrl = CTRL_LDUSE;
    else
      run_ctrl = CTRL_NORMAL;
  end

  // A stall arriving during FLUSH means the wrong-path fetch has not yet been
  // discarded; flush_pend remembers to run FLUSH once the memory wait ends.
  always_comb begin
    ctrl            = CTRL_HOLD;
    state_next      = RUN;
    flush_pend_next = flush_pend;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
        end else begin
          ctrl       = run_ctrl;
          state_next = br_taken ? FLUSH : RUN;
        end
      end
      MEM_WAIT: begin
        if (!dmem_resp) begin
          state_next = MEM_WAIT;
        end else begin
          ctrl            = run_ctrl;
          state_next      = (br_taken || flush_pend) ? FLUSH : RUN;
          flush_pend_next = 1'b0;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          state_next      = MEM_WAIT;
          flush_pend_next = 1'b1;
        end else begin
          ctrl = CTRL_FLUSH;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (reset)
      ctrl = CTRL_RESET;
  end

  assign {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
          if_id_flush, id_ex_bubble, ex_mem_flush} = ctrl;

  assign mem_wait = (state == MEM_WAIT) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      flush_pend <= flush_pend_next;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      bubble_count <= 16'd0;
    end else begin
      if (!pc_load && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (id_ex_bubble && (bubble_count != 16'hFFFF))
        bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl. Each scenario task queues the
// expected output vector as it drives a cycle of stimulus and pops it when the
// outputs are sampled on the falling edge. Define PIPE_CTRL_PERF_CNT_EN to
// also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_sr1, id_sr2, ex_dest;
  logic       id_uses_sr1, id_uses_sr2, ex_is_load, ex_valid;
  logic       imem_resp, dmem_req, dmem_resp, br_taken;
  logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic       if_id_flush, id_ex_bubble, ex_mem_flush, mem_wait;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] stall_cycles, bubble_count;
`endif

  pipeline_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_sr1       (id_sr1),
    .id_sr2       (id_sr2),
    .id_uses_sr1  (id_uses_sr1),
    .id_uses_sr2  (id_uses_sr2),
    .ex_dest      (ex_dest),
    .ex_is_load   (ex_is_load),
    .ex_valid     (ex_valid),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .br_taken     (br_taken),
    .pc_load      (pc_load),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .mem_wait     (mem_wait)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected vectors: {pc, if_id, id_ex, ex_mem, mem_wb loads,
  //                    if_id_flush, id_ex_bubble, ex_mem_flush, mem_wait}
  localparam logic [8:0] RST_O   = 9'b00000_111_0;
  localparam logic [8:0] NORM_O  = 9'b11111_000_0;
  localparam logic [8:0] HOLD_O  = 9'b00000_000_0;
  localparam logic [8:0] WAIT_O  = 9'b00000_000_1;
  localparam logic [8:0] BR_O    = 9'b11111_111_0;
  localparam logic [8:0] BRW_O   = 9'b11111_111_1;
  localparam logic [8:0] IMEM_O  = 9'b01111_100_0;
  localparam logic [8:0] LU_O    = 9'b00111_010_0;
  localparam logic [8:0] FL_O    = 9'b11111_100_0;
  // mem_wait is left unchecked on the cycles that enter or leave MEM_WAIT
  localparam logic [8:0] ALL     = 9'h1FF;
  localparam logic [8:0] NO_MW   = 9'h1FE;

  typedef struct packed {
    logic       rst;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       u1;
    logic       u2;
    logic [2:0] dest;
    logic       isload;
    logic       valid;
    logic       imem;
    logic       dreq;
    logic       dresp;
    logic       br;
  } stim_t;

  typedef struct {
    stim_t      st;
    logic [8:0] exp;
    logic [8:0] mask;
    string      name;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] outs();
    return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
            if_id_flush, id_ex_bubble, ex_mem_flush, mem_wait};
  endfunction

  // lu selects a canned load-use hazard through source 2 (ex_dest = id_sr2 = 3)
  function automatic stim_t S(input logic imem, input logic dreq,
                              input logic dresp, input logic br, input logic lu);
    stim_t s;
    s       = '0;
    s.imem  = imem;
    s.dreq  = dreq;
    s.dresp = dresp;
    s.br    = br;
    s.sr1   = 3'd5;
    s.u1    = 1'b1;
    if (lu) begin
      s.valid  = 1'b1;
      s.isload = 1'b1;
      s.dest   = 3'd3;
      s.u2     = 1'b1;
      s.sr2    = 3'd3;
    end
    return s;
  endfunction

  // Reset held for the cycle, with busy inputs that reset must override
  function automatic stim_t R();
    stim_t s;
    s     = S(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t L(input logic [2:0] dest, input logic [2:0] sr1,
                              input logic u1, input logic [2:0] sr2, input logic u2,
                              input logic isload, input logic valid);
    stim_t s;
    s        = S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s.dest   = dest;
    s.sr1    = sr1;
    s.u1     = u1;
    s.sr2    = sr2;
    s.u2     = u2;
    s.isload = isload;
    s.valid  = valid;
    return s;
  endfunction

  function automatic vec_t V(input stim_t st, input logic [8:0] exp,
                             input logic [8:0] mask, input string name);
    vec_t v;
    v.st   = st;
    v.exp  = exp;
    v.mask = mask;
    v.name = name;
    return v;
  endfunction

  task automatic apply_stimulus(input stim_t s);
    reset       = s.rst;
    id_sr1      = s.sr1;
    id_sr2      = s.sr2;
    id_uses_sr1 = s.u1;
    id_uses_sr2 = s.u2;
    ex_dest     = s.dest;
    ex_is_load  = s.isload;
    ex_valid    = s.valid;
    imem_resp   = s.imem;
    dmem_req    = s.dreq;
    dmem_resp   = s.dresp;
    br_taken    = s.br;
  endtask

  // Reset hold, async reset inside MEM_WAIT and FLUSH, pending flag cleared
  task automatic test_reset();
    vec_t v[$];
    vec_t e;
    v.push_back(V(R(),                        RST_O,  ALL,   "rst_hold"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "rst_release"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), HOLD_O, NO_MW, "mw_enter"));
    v.push_back(V(R(),                        RST_O,  ALL,   "rst_mid_memwait"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "run_after_mw_rst"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), BR_O,   ALL,   "br_before_rst"));
    v.push_back(V(R(),                        RST_O,  ALL,   "rst_mid_flush"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "run_after_fl_rst"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), BR_O,   ALL,   "br_to_flush"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), HOLD_O, NO_MW, "flush_stall_pend"));
    v.push_back(V(R(),                        RST_O,  ALL,   "rst_clears_pend"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), HOLD_O, NO_MW, "mw_enter2"));
    v.push_back(V(S(1'b1, 1'b1, 1'b1, 1'b0, 1'b0), NORM_O, NO_MW, "mw_resp_nopend"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "no_stale_flush"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Load-use detection on either source, and the conditions that suppress it
  task automatic test_load_use();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b1), LU_O,   ALL, "lu_sr2"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL, "lu_one_cycle"));
    v.push_back(V(L(3'd6, 3'd6, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1), LU_O,   ALL, "lu_sr1"));
    v.push_back(V(L(3'd6, 3'd6, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1), NORM_O, ALL, "lu_src_unused"));
    v.push_back(V(L(3'd6, 3'd6, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1), NORM_O, ALL, "lu_not_load"));
    v.push_back(V(L(3'd6, 3'd6, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0), NORM_O, ALL, "lu_ex_invalid"));
    v.push_back(V(L(3'd4, 3'd5, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1), NORM_O, ALL, "lu_no_match"));
    v.push_back(V(L(3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1), LU_O,   ALL, "lu_reg0"));
    v.push_back(V(L(3'd7, 3'd1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1), LU_O,   ALL, "lu_reg7"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Fetch wait outranks a load-use hazard
  task automatic test_imem_wait();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), IMEM_O, ALL, "imem_wait"));
    v.push_back(V(S(1'b0, 1'b0, 1'b0, 1'b0, 1'b1), IMEM_O, ALL, "imem_over_lu"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL, "imem_done"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Four-cycle data memory wait, then a wait ending into a fetch stall
  task automatic test_mem_wait();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), HOLD_O, NO_MW, "mw_cycle1"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), WAIT_O, ALL,   "mw_cycle2"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), WAIT_O, ALL,   "mw_cycle3"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), WAIT_O, ALL,   "mw_cycle4"));
    v.push_back(V(S(1'b1, 1'b1, 1'b1, 1'b0, 1'b0), NORM_O, NO_MW, "mw_resp"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "mw_run_after"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b1), HOLD_O, NO_MW, "mw_over_lu"));
    v.push_back(V(S(1'b0, 1'b1, 1'b1, 1'b0, 1'b1), IMEM_O, NO_MW, "mw_resp_imem"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b1), LU_O,   ALL,   "lu_after_mw"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Taken branch over load-use and over a fetch wait, each followed by FLUSH
  task automatic test_branch();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b1, 1'b1), BR_O,   ALL, "br_over_lu"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), FL_O,   ALL, "flush_state"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL, "run_after_flush"));
    v.push_back(V(S(1'b0, 1'b0, 1'b0, 1'b1, 1'b0), BR_O,   ALL, "br_over_imem"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b1), FL_O,   ALL, "flush_with_lu"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL, "run_after_flush2"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Branch arriving with a memory stall: wait first, flush on the response
  task automatic test_branch_stall();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), HOLD_O, NO_MW, "br_stall"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), WAIT_O, ALL,   "br_stall_wait"));
    v.push_back(V(S(1'b1, 1'b1, 1'b1, 1'b1, 1'b0), BRW_O,  ALL,   "br_on_resp"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), FL_O,   ALL,   "flush_after_resp"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "run_after_brst"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Stall during FLUSH: the postponed flush runs after the wait ends
  task automatic test_flush_stall();
    vec_t v[$];
    vec_t e;
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), BR_O,   ALL,   "br_enter_flush"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), HOLD_O, NO_MW, "flush_stall"));
    v.push_back(V(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), WAIT_O, ALL,   "pend_wait"));
    v.push_back(V(S(1'b1, 1'b1, 1'b1, 1'b0, 1'b0), NORM_O, NO_MW, "pend_resp"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), FL_O,   ALL,   "pend_flush"));
    v.push_back(V(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), NORM_O, ALL,   "run_after_pend"));
    foreach (v[i]) begin
      apply_stimulus(v[i].st);
      sb.push_back(v[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ((outs() & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("[TB] FAIL %s: observed %b expected %b", e.name, outs() & e.mask, e.exp & e.mask);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Counter start, single increments, and saturation under a long stall
  task automatic test_perf();
    int exp_stall;
    int exp_bub;
    apply_stimulus(R());
    @(negedge clk);
    exp_stall = 0;
    exp_bub   = 0;
    checks++;
    if (stall_cycles !== exp_stall[15:0] || bubble_count !== exp_bub[15:0]) begin
      errors++;
      $display("[TB] FAIL perf_reset: observed %0d/%0d expected %0d/%0d", stall_cycles, bubble_count, exp_stall, exp_bub);
    end
    @(posedge clk);
    #1;
    apply_stimulus(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    exp_stall++;
    exp_bub++;
    apply_stimulus(S(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (stall_cycles !== exp_stall[15:0] || bubble_count !== exp_bub[15:0]) begin
      errors++;
      $display("[TB] FAIL perf_load_use: observed %0d/%0d expected %0d/%0d", stall_cycles, bubble_count, exp_stall, exp_bub);
    end
    @(posedge clk);
    #1;
    exp_stall++;
    apply_stimulus(S(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (stall_cycles !== exp_stall[15:0] || bubble_count !== exp_bub[15:0]) begin
      errors++;
      $display("[TB] FAIL perf_imem: observed %0d/%0d expected %0d/%0d", stall_cycles, bubble_count, exp_stall, exp_bub);
    end
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      if (exp_stall < 65535)
        exp_stall++;
    end
    #1;
    @(negedge clk);
    checks++;
    if (stall_cycles !== exp_stall[15:0] || bubble_count !== exp_bub[15:0]) begin
      errors++;
      $display("[TB] FAIL perf_saturate: observed %0d/%0d expected %0d/%0d", stall_cycles, bubble_count, exp_stall, exp_bub);
    end
    @(posedge clk);
    #1;
    apply_stimulus(R());
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL perf_rst_mid_wait: observed %0d/%0d expected 0/0", stall_cycles, bubble_count);
    end
    @(posedge clk);
    #1;
    apply_stimulus(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    apply_stimulus(S(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    #1;
    test_reset();
    test_load_use();
    test_imem_wait();
    test_mem_wait();
    test_branch();
    test_branch_stall();
    test_flush_stall();
`ifdef PIPE_CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
